// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/BREATHE modes rendered by one shared PWM
// counter, with config double-buffered so changes only ever land on PWM frame boundaries.
module led_pattern_gen #(
  parameter int CHANNELS   = 9,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 64,
  parameter int PHASE_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_chan,
  input  logic [1:0]            cfg_mode,
  input  logic [PWM_BITS-1:0]   cfg_level,
  output logic [CHANNELS-1:0]   led,
  output logic                  frame_strobe,
  output logic [PHASE_BITS-1:0] phase
);

  localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TRI_W  = PHASE_BITS - 1;
  localparam int PROD_W = 2 * PWM_BITS + 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e               mode;
    logic [PWM_BITS-1:0] level;
  } chan_cfg_t;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PS_W-1:0]     prescale_cnt;
  logic                wrap;
  logic                phase_tick;
  logic [TRI_W-1:0]    tri_pos;
  logic [PWM_BITS-1:0] breathe_b;
  chan_cfg_t           shadow [CHANNELS];
  chan_cfg_t           active [CHANNELS];
  logic [PWM_BITS-1:0] duty   [CHANNELS];

  assign wrap       = (pwm_cnt == '1);
  assign phase_tick = wrap && (prescale_cnt == PS_W'(PRESCALE - 1));

  // Triangle wave: the lower phase bits count up, then count down once the MSB is set.
  assign tri_pos   = phase[TRI_W-1:0] ^ {TRI_W{phase[PHASE_BITS-1]}};
  assign breathe_b = PWM_BITS'(tri_pos >> (TRI_W - PWM_BITS));

  function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] b,
                                                input logic [PWM_BITS-1:0] level);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(b) * (PROD_W'(level) + PROD_W'(1));
    return PWM_BITS'(prod >> PWM_BITS);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_cnt      <= '0;
      prescale_cnt <= '0;
      phase        <= '0;
      frame_strobe <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + 1'b1;
      frame_strobe <= (pwm_cnt == '0);
      if (wrap) begin
        prescale_cnt <= (prescale_cnt == PS_W'(PRESCALE - 1)) ? '0 : prescale_cnt + 1'b1;
      end
      if (phase_tick) begin
        phase <= phase + 1'b1;
      end
    end
  end

  // NOTE: the shadow/active banks are plain flop arrays, so they take the reset like any other state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        // Active copies the pre-edge shadow, so a write in the wrap cycle waits one more frame.
        if (wrap) begin
          active[i] <= shadow[i];
        end
        if (cfg_we && (cfg_chan == 5'(i))) begin
          shadow[i] <= '{mode: mode_e'(cfg_mode), level: cfg_level};
        end
      end
    end
  end

  // NOTE: duty gets its default before the case so no path through the block can infer a latch.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty[i] = '0;
      case (active[i].mode)
        MODE_OFF:     duty[i] = '0;
        MODE_ON:      duty[i] = active[i].level;
        MODE_BLINK:   duty[i] = phase[PHASE_BITS-1] ? '0 : active[i].level;
        MODE_BREATHE: duty[i] = scale(breathe_b, active[i].level);
        default:      duty[i] = '0;
      endcase
    end
  end

  // Full-scale duty is forced high so the LED never drops for the one cycle pwm_cnt can't exceed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        led[i] <= (duty[i] == '1) || (pwm_cnt < duty[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed scenarios plus random config traffic,
// compared against a frame-level arithmetic model of the LED timing.
module tb_led_pattern_gen;

  localparam int CH    = 3;
  localparam int PW    = 4;
  localparam int PS    = 2;
  localparam int PH    = 6;
  localparam int FRAME = 1 << PW;
  localparam int FULL  = FRAME - 1;
  localparam int HALF  = 1 << (PH - 1);

  localparam int M_OFF     = 0;
  localparam int M_ON      = 1;
  localparam int M_BLINK   = 2;
  localparam int M_BREATHE = 3;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          cfg_we    = 1'b0;
  logic [4:0]    cfg_chan  = '0;
  logic [1:0]    cfg_mode  = '0;
  logic [PW-1:0] cfg_level = '0;
  logic [CH-1:0] led;
  logic          frame_strobe;
  logic [PH-1:0] phase;

  led_pattern_gen #(
    .CHANNELS  (CH),
    .PWM_BITS  (PW),
    .PRESCALE  (PS),
    .PHASE_BITS(PH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_chan    (cfg_chan),
    .cfg_mode    (cfg_mode),
    .cfg_level   (cfg_level),
    .led         (led),
    .frame_strobe(frame_strobe),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: k counts clock edges since the last reset edge; config is tracked per frame.
  int            k;
  int            sh_mode  [CH];
  int            sh_level [CH];
  int            act_mode [CH];
  int            act_level[CH];
  logic [CH-1:0] exp_led;
  logic          exp_fs;
  logic [PH-1:0] exp_phase;

  function automatic int phase_of(input int frame);
    return (frame / PS) % (1 << PH);
  endfunction

  function automatic int duty_of(input int mode, input int level, input int ph);
    int d, tri_v, b;
    d = 0;
    case (mode)
      M_ON:    d = level;
      M_BLINK: d = (ph < HALF) ? level : 0;
      M_BREATHE: begin
        tri_v = (ph < HALF) ? (ph % HALF) : (HALF - 1 - (ph % HALF));
        b     = tri_v / (1 << (PH - 1 - PW));
        d     = (b * (level + 1)) / FRAME;
      end
      default: d = 0;
    endcase
    return d;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < CH; c++) begin
      sh_mode[c]   = 0;
      sh_level[c]  = 0;
      act_mode[c]  = 0;
      act_level[c] = 0;
    end
  endtask

  // One clock: compute what the outputs must show after the edge, then advance the model.
  task automatic step();
    int p, f, d, c;
    p = k % FRAME;
    f = k / FRAME;
    for (int i = 0; i < CH; i++) begin
      d = duty_of(act_mode[i], act_level[i], phase_of(f));
      exp_led[i] = (d == FULL) || (p < d);
    end
    exp_fs    = (p == 0);
    exp_phase = PH'(phase_of((k + 1) / FRAME));
    @(posedge clk);
    k++;
    if (k % FRAME == 0) begin
      for (int i = 0; i < CH; i++) begin
        act_mode[i]  = sh_mode[i];
        act_level[i] = sh_level[i];
      end
    end
    c = int'(cfg_chan);
    if (cfg_we && c < CH) begin
      sh_mode[c]  = int'(cfg_mode);
      sh_level[c] = int'(cfg_level);
    end
    #1;
  endtask

  task automatic write(input int ch, input int mode, input int level);
    cfg_we    = 1'b1;
    cfg_chan  = 5'(ch);
    cfg_mode  = 2'(mode);
    cfg_level = PW'(level);
    step();
    cfg_we    = 1'b0;
  endtask

  // Steps at least once, stopping where the next edge starts a new frame.
  task automatic align();
    step();
    for (int i = 0; i < FRAME && (k % FRAME) != 0; i++) step();
  endtask

  task automatic measure_frame(input int ch, output int hi, output bit shape_ok);
    int runs;
    bit prev, first;
    align();
    hi = 0; runs = 0; prev = 1'b0; first = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (led[ch]) begin
        hi++;
        if (!prev) runs++;
        if (i == 0) first = 1'b1;
      end
      prev = led[ch];
    end
    shape_ok = (hi == 0) || (first && runs == 1);
  endtask

  task automatic test_reset();
    int fs_cnt;
    fs_cnt = 0;
    reset  = 1'b0;
    cfg_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if (led !== '0 || frame_strobe !== 1'b0 || phase !== '0) begin
      n_miss++;
      $display("FAIL reset_state led=%b fs=%b phase=%0d, want 0/0/0", led, frame_strobe, phase);
    end
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      n_vec++;
      if (led !== exp_led || frame_strobe !== exp_fs || phase !== exp_phase) begin
        n_miss++;
        $display("FAIL idle k=%0d led=%b want %b fs=%b want %b phase=%0d want %0d",
                 k, led, exp_led, frame_strobe, exp_fs, phase, exp_phase);
      end
      if (i == 0) begin
        n_vec++;
        if (frame_strobe !== 1'b1) begin
          n_miss++;
          $display("FAIL first_strobe got %b want 1", frame_strobe);
        end
      end
      if (frame_strobe === 1'b1) fs_cnt++;
    end
    n_vec++;
    if (fs_cnt != 13) begin
      n_miss++;
      $display("FAIL strobe_count got %0d want 13", fs_cnt);
    end
  endtask

  task automatic test_on_duty();
    int hi;
    bit shape_ok;
    write(0, M_ON, 5);
    for (int r = 0; r < 2; r++) begin
      measure_frame(0, hi, shape_ok);
      n_vec++;
      if (hi != 5 || !shape_ok) begin
        n_miss++;
        $display("FAIL on_level5 high=%0d shape=%0b want 5/1", hi, shape_ok);
      end
    end
    write(0, M_ON, FULL);
    measure_frame(0, hi, shape_ok);
    n_vec++;
    if (hi != FRAME) begin
      n_miss++;
      $display("FAIL on_full high=%0d want %0d", hi, FRAME);
    end
    write(0, M_ON, 0);
    measure_frame(0, hi, shape_ok);
    n_vec++;
    if (hi != 0) begin
      n_miss++;
      $display("FAIL on_zero high=%0d want 0", hi);
    end
  endtask

  task automatic test_glitch_free();
    int cnt;
    write(1, M_ON, 8);
    align();
    cnt = 0;
    repeat (3) begin step(); cnt += int'(led[1]); end
    write(1, M_ON, 2);
    cnt += int'(led[1]);
    repeat (12) begin step(); cnt += int'(led[1]); end
    n_vec++;
    if (cnt != 8) begin n_miss++; $display("FAIL midframe_write_cur high=%0d want 8", cnt); end
    cnt = 0;
    repeat (16) begin step(); cnt += int'(led[1]); end
    n_vec++;
    if (cnt != 2) begin n_miss++; $display("FAIL midframe_write_next high=%0d want 2", cnt); end
    cnt = 0;
    repeat (15) begin step(); cnt += int'(led[1]); end
    write(1, M_ON, 8);
    cnt += int'(led[1]);
    n_vec++;
    if (cnt != 2) begin n_miss++; $display("FAIL wrap_write_cur high=%0d want 2", cnt); end
    cnt = 0;
    repeat (16) begin step(); cnt += int'(led[1]); end
    n_vec++;
    if (cnt != 2) begin n_miss++; $display("FAIL wrap_write_next high=%0d want 2", cnt); end
    cnt = 0;
    repeat (16) begin step(); cnt += int'(led[1]); end
    n_vec++;
    if (cnt != 8) begin n_miss++; $display("FAIL wrap_write_later high=%0d want 8", cnt); end
  endtask

  task automatic test_blink();
    int hi;
    write(2, M_BLINK, FULL);
    align();
    hi = 0;
    for (int i = 0; i < 2048; i++) begin
      step();
      n_vec++;
      if (led !== exp_led) begin
        n_miss++;
        $display("FAIL blink_model k=%0d led=%b want %b", k, led, exp_led);
      end
      if (led[2]) hi++;
      if (i % FRAME == 8) begin
        n_vec++;
        if (led[2] !== (phase < HALF)) begin
          n_miss++;
          $display("FAIL blink_level phase=%0d led2=%b want %b", phase, led[2], phase < HALF);
        end
      end
    end
    n_vec++;
    if (hi != 1024) begin n_miss++; $display("FAIL blink_total high=%0d want 1024", hi); end
  endtask

  task automatic test_breathe();
    int hi, ph, e, want;
    write(0, M_BREATHE, FULL);
    align();
    for (int f = 0; f < 128; f++) begin
      hi = 0;
      ph = 0;
      for (int p = 0; p < FRAME; p++) begin
        step();
        n_vec++;
        if (led !== exp_led) begin
          n_miss++;
          $display("FAIL breathe_model k=%0d led=%b want %b", k, led, exp_led);
        end
        if (led[0]) hi++;
        if (p == 8) ph = int'(phase);
      end
      e    = (ph < HALF) ? (ph % HALF) / 2 : FULL - (ph % HALF) / 2;
      want = (e == FULL) ? FRAME : e;
      n_vec++;
      if (hi != want) begin
        n_miss++;
        $display("FAIL breathe_frame phase=%0d high=%0d want %0d", ph, hi, want);
      end
    end
  endtask

  task automatic test_robustness();
    int hi;
    bit shape_ok;
    write(7, M_ON, FULL);
    for (int i = 0; i < 48; i++) begin
      step();
      n_vec++;
      if (led !== exp_led || phase !== exp_phase) begin
        n_miss++;
        $display("FAIL oor_write k=%0d led=%b want %b", k, led, exp_led);
      end
    end
    measure_frame(1, hi, shape_ok);
    n_vec++;
    if (hi != 8) begin n_miss++; $display("FAIL oor_ch1 high=%0d want 8", hi); end
    for (int c = 0; c < CH; c++) write(c, M_ON, 9);
    align();
    repeat (5) step();
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (led !== '0 || frame_strobe !== 1'b0 || phase !== '0) begin
      n_miss++;
      $display("FAIL midframe_reset led=%b fs=%b phase=%0d, want 0/0/0", led, frame_strobe, phase);
    end
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      n_vec++;
      if (led !== '0 || frame_strobe !== exp_fs || phase !== exp_phase) begin
        n_miss++;
        $display("FAIL post_reset k=%0d led=%b want 0 fs=%b want %b", k, led, frame_strobe, exp_fs);
      end
    end
    write(0, M_ON, FULL);
    measure_frame(0, hi, shape_ok);
    n_vec++;
    if (hi != FRAME) begin n_miss++; $display("FAIL rewrite_after_reset high=%0d want %0d", hi, FRAME); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_we    = 1'b1;
        cfg_chan  = 5'($urandom_range(0, 7));
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_level = PW'($urandom_range(0, FULL));
      end else begin
        cfg_we = 1'b0;
      end
      step();
      n_vec++;
      if (led !== exp_led || frame_strobe !== exp_fs || phase !== exp_phase) begin
        n_miss++;
        $display("FAIL random k=%0d led=%b want %b fs=%b want %b phase=%0d want %0d",
                 k, led, exp_led, frame_strobe, exp_fs, phase, exp_phase);
      end
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_on_duty();
    test_glitch_free();
    test_blink();
    test_breathe();
    test_robustness();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete, %0d miscompares so far", n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
